bht_update_scheduler: RTL

BHT_UPDATE_SCHEDULER -- requirements
Module: bht_update_scheduler

---
 rtl/bht_update_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/bht_update_scheduler.sv
// Ordered update queue sitting in front of a branch history table: resolved-branch
// updates are buffered and drained one per cycle while fetch lookups read freely.
module bht_update_scheduler #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [LOWER-1:0]          upd_addr,
  input  logic                      upd_taken,
  input  logic                      upd_jump,
  input  logic                      fetch_valid,
  input  logic [LOWER-1:0]          fetch_addr,
  input  logic                      bht_hold,
  output logic                      bht_rd_en,
  output logic [LOWER-1:0]          bht_read_addr,
  output logic                      bht_wr_en,
  output logic [LOWER-1:0]          bht_write_addr,
  output logic                      bht_was_taken,
  output logic                      bht_jumped,
  output logic                      pred_stale,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [15:0]               upd_count,
  output logic [15:0]               stale_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  // Entry layout: {addr, taken, jump}
  logic [LOWER+1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;

  assign upd_ready     = (occupancy < FULL);
  assign push          = upd_valid & upd_ready;
  assign pop           = (occupancy != '0) & ~bht_hold;

  assign bht_rd_en     = fetch_valid;
  assign bht_read_addr = fetch_addr;

  assign bht_wr_en      = pop;
  assign bht_write_addr = pop ? mem[head][LOWER+1:2] : '0;
  assign bht_was_taken  = pop ? mem[head][1] : 1'b0;
  assign bht_jumped     = pop ? mem[head][0] : 1'b0;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    pred_stale = 1'b0;
    if (fetch_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (({1'b0, PW'(PW'(i) - head)} < occupancy) &&
            (mem[i][LOWER+1:2] == fetch_addr)) begin
          pred_stale = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {upd_addr, upd_taken, upd_jump};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      upd_count   <= '0;
      stale_count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (push && (upd_count != 16'hFFFF)) begin
        upd_count <= upd_count + 16'd1;
      end
      if (pred_stale && (stale_count != 16'hFFFF)) begin
        stale_count <= stale_count + 16'd1;
      end
    end
  end

endmodule
